hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall sequencer for the 5-stage CPU. Sits beside the ID stage, next to
//  the sign extender that feeds both the ID/EX register and the branch-target adder.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch hazard sequencer for the ID stage of the 5-stage pipeline.
// Optional statistic counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,
  parameter int BR_FLUSH_SLOTS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        branch_i,
  input  logic        equal_i,
  input  logic        mem_stall_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        pcsrc_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] BR_INIT = 3'(BR_FLUSH_SLOTS - 1);

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic       lu_s;
  logic       stall_inc_s;
  logic       flush_inc_s;

  assign lu_s = ex_memread_i && (ex_rt_i != 5'd0) &&
                ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  // State and remaining-cycle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and pipeline control outputs; memory stall freezes everything
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pcsrc_o        = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    stall_inc_s    = 1'b0;
    flush_inc_s    = 1'b0;
    if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_inc_s    = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              state_nxt_s = LU_WAIT;
              cnt_nxt_s   = LU_INIT;
            end else begin
              state_nxt_s = RUN;
              cnt_nxt_s   = 3'd0;
            end
          end else if (branch_i && equal_i) begin
            pcsrc_o       = 1'b1;
            if_id_flush_o = 1'b1;
            flush_inc_s   = 1'b1;
            if (BR_FLUSH_SLOTS > 1) begin
              state_nxt_s = FLUSH;
              cnt_nxt_s   = BR_INIT;
            end else begin
              state_nxt_s = RUN;
              cnt_nxt_s   = 3'd0;
            end
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
          end
        end
        LU_WAIT: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          stall_inc_s    = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            cnt_nxt_s = cnt_r - 3'd1;
          end
        end
        FLUSH: begin
          if_id_flush_o = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            cnt_nxt_s = cnt_r - 3'd1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      sat_inc = v + 16'd1;
    end else begin
      sat_inc = v;
    end
  endfunction

  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = stall_inc_s ^ flush_inc_s;
  assign stall_cnt_o    = 16'h0000;
  assign flush_cnt_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (stretched and default lengths) against a
// remaining-cycles reference model, with directed scenarios followed by random traffic.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
  logic        ex_memread_i, branch_i, equal_i, mem_stall_i;

  logic [4:0]  obs_a, obs_b;
  logic [15:0] st_a, fl_a, st_b, fl_b;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 = (3,2) instance, index 1 = default (1,1)
  int lu_par[2] = '{3, 1};
  int br_par[2] = '{2, 1};
  int lu_rem[2];
  int fl_rem[2];
  int st_cnt[2];
  int fl_cnt[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_STALL(3), .BR_FLUSH_SLOTS(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .branch_i(branch_i),
    .equal_i(equal_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(obs_a[4]), .if_id_write_o(obs_a[3]), .if_id_flush_o(obs_a[2]),
    .id_ex_bubble_o(obs_a[1]), .pcsrc_o(obs_a[0]),
    .stall_cnt_o(st_a), .flush_cnt_o(fl_a));

  hazard_ctrl u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .branch_i(branch_i),
    .equal_i(equal_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(obs_b[4]), .if_id_write_o(obs_b[3]), .if_id_flush_o(obs_b[2]),
    .id_ex_bubble_o(obs_b[1]), .pcsrc_o(obs_b[0]),
    .stall_cnt_o(st_b), .flush_cnt_o(fl_b));

  function automatic logic lu_now();
    return ex_memread_i && (ex_rt_i != 5'd0) &&
           ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  endfunction

  // expected {pc_write, if_id_write, flush, bubble, pcsrc}
  function automatic logic [4:0] exp_out(int k);
    if (rst_i)               return 5'b11000;
    if (mem_stall_i)         return 5'b00000;
    if (lu_rem[k] > 0)       return 5'b00010;
    if (fl_rem[k] > 0)       return 5'b11100;
    if (lu_now())            return 5'b00010;
    if (branch_i && equal_i) return 5'b11101;
    return 5'b11000;
  endfunction

  function automatic int exp_stat(int v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lu_rem[k] = 0; fl_rem[k] = 0; st_cnt[k] = 0; fl_cnt[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (mem_stall_i) begin
        // frozen
      end else if (lu_rem[k] > 0) begin
        lu_rem[k]--;
        if (st_cnt[k] < 65535) st_cnt[k]++;
      end else if (fl_rem[k] > 0) begin
        fl_rem[k]--;
      end else if (lu_now()) begin
        lu_rem[k] = lu_par[k] - 1;
        if (st_cnt[k] < 65535) st_cnt[k]++;
      end else if (branch_i && equal_i) begin
        fl_rem[k] = br_par[k] - 1;
        if (fl_cnt[k] < 65535) fl_cnt[k]++;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [4:0]  e_a, e_b;
    logic [15:0] es_a, ef_a, es_b, ef_b;
    e_a  = exp_out(0);
    e_b  = exp_out(1);
    es_a = 16'(exp_stat(st_cnt[0]));
    ef_a = 16'(exp_stat(fl_cnt[0]));
    es_b = 16'(exp_stat(st_cnt[1]));
    ef_b = 16'(exp_stat(fl_cnt[1]));
    n_checks++;
    assert (obs_a === e_a) else begin
      n_fail++; $error("FAIL %s ctrl_a observed=%b expected=%b", tag, obs_a, e_a);
    end
    n_checks++;
    assert (obs_b === e_b) else begin
      n_fail++; $error("FAIL %s ctrl_b observed=%b expected=%b", tag, obs_b, e_b);
    end
    n_checks++;
    assert ({st_a, fl_a} === {es_a, ef_a}) else begin
      n_fail++; $error("FAIL %s stats_a observed=%0d/%0d expected=%0d/%0d", tag, st_a, fl_a, es_a, ef_a);
    end
    n_checks++;
    assert ({st_b, fl_b} === {es_b, ef_b}) else begin
      n_fail++; $error("FAIL %s stats_b observed=%0d/%0d expected=%0d/%0d", tag, st_b, fl_b, es_b, ef_b);
    end
  endtask

  task automatic idle();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
    ex_memread_i = 1'b0; branch_i = 1'b0; equal_i = 1'b0; mem_stall_i = 1'b0;
  endtask

  task automatic set_lu();
    idle(); ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; id_rt_i = 5'd9;
  endtask

  // check combinational outputs, then advance one clock and the model with it
  task automatic step(input string tag);
    #1;
    check(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    model_reset();
    #2;
    check("reset_state");
    @(posedge clk); #1;
    check("reset_held");
    rst_i = 1'b0;

    // default load-use: single bubble on instance b, three on instance a
    set_lu(); step("lu_first");
    idle();   step("lu_after1");
    step("lu_after2");
    step("lu_after3");

    // rt-match and rt==0 never stalls
    set_lu(); id_rs_i = 5'd1; id_rt_i = 5'd5; step("lu_rt_match");
    idle(); step("lu_rt_w1"); step("lu_rt_w2");
    idle(); ex_memread_i = 1'b1; step("lu_zero_reg");

    // taken branch, then not-taken branch
    idle(); branch_i = 1'b1; equal_i = 1'b1; step("br_taken");
    idle(); step("br_slot2");
    step("br_run");
    branch_i = 1'b1; step("br_not_taken");

    // load-use and taken branch together; branch re-evaluated after the stall
    set_lu(); branch_i = 1'b1; equal_i = 1'b1; step("lu_br_both");
    ex_memread_i = 1'b0; step("lu_br_1");
    step("lu_br_2");
    step("lu_br_3");
    idle(); step("lu_br_4");

    // memory stall holds LU_WAIT countdown
    set_lu(); step("ms_enter");
    idle(); mem_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) step("ms_hold");
    mem_stall_i = 1'b0;
    step("ms_rel1"); step("ms_rel2"); step("ms_run");
    mem_stall_i = 1'b1; branch_i = 1'b1; equal_i = 1'b1; step("ms_over_br");

    // asynchronous reset in the middle of LU_WAIT
    set_lu(); step("rst_pre");
    idle(); rst_i = 1'b1;
    model_reset();
    #1;
    check("rst_mid_wait");
    @(posedge clk); #1;
    check("rst_next_edge");
    rst_i = 1'b0;

    // three load-use events and two taken branches for the statistics
    for (int i = 0; i < 3; i++) begin
      set_lu(); step("stat_lu");
      idle(); step("stat_gap"); step("stat_gap"); step("stat_gap");
    end
    for (int i = 0; i < 2; i++) begin
      idle(); branch_i = 1'b1; equal_i = 1'b1; step("stat_br");
      idle(); step("stat_gap"); step("stat_gap");
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ex_memread_i = ($urandom_range(0, 2) == 0);
      ex_rt_i      = 5'($urandom_range(0, 3));
      id_rs_i      = 5'($urandom_range(0, 3));
      id_rt_i      = 5'($urandom_range(0, 3));
      branch_i     = ($urandom_range(0, 2) == 0);
      equal_i      = 1'($urandom_range(0, 1));
      mem_stall_i  = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
